// File: rtl/fifo_pkg.sv
// Shared defaults and read-mode constants for the parameterised FIFO.
// Also holds the threshold legality helper used at elaboration.
package fifo_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_AE_LVL = 4;
    localparam int AF_MARGIN  = 4;

    localparam bit FWFT_REG = 1'b0;
    localparam bit FWFT_ON  = 1'b1;

    function automatic bit lvl_ok(input int ae, input int af, input int depth);
        return (ae >= 1) && (ae < af) && (af <= depth);
    endfunction

endpackage

// File: rtl/fifo_param_ram.sv
// Simple dual-port storage: one synchronous write port, one async read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read). No reset.
module fifo_param_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// Synchronous FIFO with level flags, sticky errors and registered/FWFT read.
// Ports: clk, rst (async low), flush, wr_en/din, rd_en/dout/dout_valid,
// empty/full/almost_empty/almost_full, count, overflow/underflow, clr_err.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int AF_LVL = (1 << ADDR_W) - AF_MARGIN,
    parameter int AE_LVL = DEF_AE_LVL,
    parameter bit FWFT   = FWFT_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = ADDR_W + 1;

    localparam logic [ADDR_W:0] DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = CW'(AF_LVL);
    localparam logic [ADDR_W:0] AE_C    = CW'(AE_LVL);

    generate
        if (!lvl_ok(AE_LVL, AF_LVL, DEPTH)) begin : g_bad_lvl
            $error("fifo_param: need 1 <= AE_LVL < AF_LVL <= DEPTH");
        end
    endgenerate

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_acc;
    logic              rd_acc;
    logic              wr_rej;
    logic              rd_rej;

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_empty = (count <= AE_C);
    assign almost_full  = (count >= AF_C);

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
    assign rd_acc = rd_en && !flush && !empty;
    assign wr_acc = wr_en && !flush && (!full || rd_acc);
    assign wr_rej = wr_en && !flush && !wr_acc;
    assign rd_rej = rd_en && !flush && !rd_acc;

    fifo_param_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (1'b1)
                (wr_acc && !rd_acc): count <= count + 1'b1;
                (rd_acc && !wr_acc): count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Set beats clear so an error in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_rej) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_rej) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT == FWFT_ON) begin : g_fwft
            assign dout       = rd_data;
            assign dout_valid = !empty;
        end else begin : g_reg
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dout       <= '0;
                    dout_valid <= 1'b0;
                end else if (flush) begin
                    dout_valid <= 1'b0;
                end else begin
                    dout_valid <= rd_acc;
                    if (rd_acc) begin
                        dout <= rd_data;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// Randomised and directed bench for fifo_param in both read modes.
// A queue-based model predicts every output each cycle.
module tb_fifo_param;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        clr_err = 1'b0;
    logic [31:0] din = '0;

    logic [31:0] r_dout, f_dout;
    logic        r_dv, f_dv;
    logic        r_empty, r_full, r_ae, r_af, r_ovf, r_udf;
    logic        f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
    logic [5:0]  r_count, f_count;

    always #5 clk = ~clk;

    fifo_param #(.FWFT(1'b0)) u_reg (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_en(wr_en), .din(din), .rd_en(rd_en), .clr_err(clr_err),
        .dout(r_dout), .dout_valid(r_dv),
        .empty(r_empty), .full(r_full),
        .almost_empty(r_ae), .almost_full(r_af),
        .count(r_count), .overflow(r_ovf), .underflow(r_udf)
    );

    fifo_param #(.FWFT(1'b1)) u_ft (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_en(wr_en), .din(din), .rd_en(rd_en), .clr_err(clr_err),
        .dout(f_dout), .dout_valid(f_dv),
        .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af),
        .count(f_count), .overflow(f_ovf), .underflow(f_udf)
    );

    logic [31:0] q[$];
    logic [31:0] m_dout;
    bit          m_dv, m_ovf, m_udf;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_dout = '0;
        m_dv   = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    always @(negedge rst) m_reset();

    always @(posedge clk) begin
        int  n;
        bit  rd_ok, wr_ok;
        if (!rst) begin
            m_reset();
        end else begin
            n     = q.size();
            rd_ok = rd_en && !flush && (n > 0);
            wr_ok = wr_en && !flush && ((n < DEPTH) || rd_ok);
            if (wr_en && !flush && !wr_ok) m_ovf = 1'b1;
            else if (clr_err)             m_ovf = 1'b0;
            if (rd_en && !flush && !rd_ok) m_udf = 1'b1;
            else if (clr_err)             m_udf = 1'b0;
            if (flush) begin
                q.delete();
                m_dv = 1'b0;
            end else begin
                m_dv = rd_ok;
                if (rd_ok) m_dout = q.pop_front();
                if (wr_ok) q.push_back(din);
            end
        end
    end

    always @(negedge clk) begin
        int n;
        if (chk_en) begin
            n = q.size();
            chk("r_count", r_count, n);
            chk("r_empty", r_empty, n == 0);
            chk("r_full", r_full, n == DEPTH);
            chk("r_ae", r_ae, n <= 4);
            chk("r_af", r_af, n >= DEPTH - 4);
            chk("r_ovf", r_ovf, m_ovf);
            chk("r_udf", r_udf, m_udf);
            chk("r_dv", r_dv, m_dv);
            chk("r_dout", r_dout, m_dout);
            chk("f_count", f_count, n);
            chk("f_ovf", f_ovf, m_ovf);
            chk("f_udf", f_udf, m_udf);
            chk("f_dv", f_dv, n > 0);
            if (n > 0) chk("f_dout", f_dout, q[0]);
        end
    end

    task automatic cyc(input bit we, input bit re, input logic [31:0] d,
                       input bit fl = 1'b0, input bit ce = 1'b0);
        @(negedge clk);
        #2;
        wr_en   = we;
        rd_en   = re;
        din     = d;
        flush   = fl;
        clr_err = ce;
    endtask

    task automatic drain();
        int k;
        cyc(0, 0, 0);
        k = q.size();
        repeat (k) cyc(0, 1, 0);
        cyc(0, 0, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_count", r_count, 0);
        chk("rst_empty", r_empty, 1);
        chk("rst_ae", r_ae, 1);
        chk("rst_full", r_full, 0);
        chk("rst_af", r_af, 0);
        chk("rst_dv", r_dv, 0);
        chk("rst_dout", r_dout, 0);
        chk("rst_ovf", r_ovf, 0);
        #2;
        rst    = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i <= DEPTH; i++) cyc(1, 0, i);
        cyc(0, 0, 0);
        chk("fill_count", r_count, 32);
        chk("fill_full", r_full, 1);
        chk("fill_ovf", r_ovf, 1);

        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 1, 0);
            if (i > 0) chk("rd_seq", r_dout, i - 1);
        end
        cyc(0, 0, 0);
        chk("rd_last", r_dout, 31);
        chk("rd_last_dv", r_dv, 1);
        chk("rd_empty", r_empty, 1);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("rd_udf", r_udf, 1);
        chk("rd_udf_dv", r_dv, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0);
        chk("clr_udf", r_udf, 0);

        for (int i = 0; i < 28; i++) cyc(1, 0, 100 + i);
        for (int i = 0; i < 10; i++) cyc(1, 1, 200 + i);
        cyc(0, 0, 0);
        chk("rw_count", r_count, 28);
        chk("rw_af", r_af, 1);
        chk("rw_dout", r_dout, 109);
        drain();

        cyc(1, 0, 32'hA5);
        cyc(0, 0, 0);
        chk("ft_dout", f_dout, 32'hA5);
        chk("ft_dv", f_dv, 1);
        chk("ft_reg_dv", r_dv, 0);

        for (int i = 0; i < 9; i++) cyc(1, 0, 50 + i);
        cyc(0, 0, 0);
        chk("pre_flush", r_count, 10);
        cyc(1, 0, 77, 1);
        cyc(0, 0, 0);
        chk("fl_count", r_count, 0);
        chk("fl_empty", r_empty, 1);
        chk("fl_ovf", r_ovf, 0);
        cyc(1, 0, 32'h1234);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("fl_rdback", r_dout, 32'h1234);

        for (int i = 0; i < 17; i++) cyc(1, 0, 400 + i);
        cyc(0, 0, 0);
        chk("pre_rst", r_count, 17);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_count", r_count, 0);
        chk("arst_empty", r_empty, 1);
        chk("arst_ae", r_ae, 1);
        chk("arst_full", r_full, 0);
        chk("arst_af", r_af, 0);
        chk("arst_dv", r_dv, 0);
        chk("arst_dout", r_dout, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 300 + i);
        cyc(0, 0, 0);
        chk("post_count", r_count, 32);
        chk("post_full", r_full, 1);
        chk("post_ovf", r_ovf, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("post_addr0", r_dout, 300);
        drain();

        for (int i = 0; i < 3000; i++) begin
            int ph, pw, pr;
            ph = (i / 250) % 4;
            pw = (ph == 0) ? 85 : (ph == 1) ? 15 : 50;
            pr = (ph == 0) ? 20 : (ph == 1) ? 85 : (ph == 2) ? 50 : 60;
            cyc($urandom_range(0, 99) < pw,
                $urandom_range(0, 99) < pr,
                $urandom,
                $urandom_range(0, 99) < 1,
                $urandom_range(0, 99) < 4);
        end
        cyc(0, 0, 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
